// File: rtl/imm_enc_if.sv
// rtl/imm_enc_if.sv - request/result bundle for the immediate encoder
interface imm_enc_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  ImmSrc;
   logic [31:0] ImmIn;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] Instr;
   logic [1:0]  ErrCode;
   logic [7:0]  ErrCount;

   modport master (
      output in_valid, ImmSrc, ImmIn, out_ready,
      input  in_ready, out_valid, Instr, ErrCode, ErrCount
   );

   modport slave (
      input  in_valid, ImmSrc, ImmIn, out_ready,
      output in_ready, out_valid, Instr, ErrCode, ErrCount
   );
endinterface

// File: rtl/imm_enc.sv
// rtl/imm_enc.sv - two-stage RV32I immediate encoder with error flags
module imm_enc (
   input logic      clk,
   input logic      rst,
   imm_enc_if.slave bus
);
   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_RANGE = 2'b01;
   localparam logic [1:0] ERR_ALIGN = 2'b10;
   localparam logic [1:0] ERR_FMT   = 2'b11;

   logic        s1Valid;
   logic [2:0]  s1Src;
   logic [31:0] s1Imm;
   logic        s2Valid;
   logic [24:0] s2Instr;
   logic [1:0]  s2Err;
   logic [7:0]  errCnt;

   logic        s2Adv;
   logic        s1Adv;
   logic [24:0] encInstr;
   logic [1:0]  encErr;

   // Sign-extension checks: the listed upper bits must be all ones or all zeros
   logic rngIS;
   logic rngB;
   logic rngJ;
   assign rngIS = (&s1Imm[31:11]) | ~(|s1Imm[31:11]);
   assign rngB  = (&s1Imm[31:12]) | ~(|s1Imm[31:12]);
   assign rngJ  = (&s1Imm[31:20]) | ~(|s1Imm[31:20]);

   // S2 may load whenever it is empty or being drained this cycle
   assign s2Adv = !s2Valid || bus.out_ready;
   assign s1Adv = !s1Valid || s2Adv;

   assign bus.in_ready  = s1Adv;
   assign bus.out_valid = s2Valid;
   assign bus.Instr     = s2Instr;
   assign bus.ErrCode   = s2Err;
   assign bus.ErrCount  = errCnt;

   // Scatter immediate bits into instruction positions; errors keep the truncated mapping
   always_comb begin
      encInstr = '0;
      encErr   = ERR_OK;
      unique case (s1Src)
         3'b000: begin
            encInstr[24:13] = s1Imm[11:0];
            if (!rngIS) encErr = ERR_RANGE;
         end
         3'b001: begin
            encInstr[24:18] = s1Imm[11:5];
            encInstr[4:0]   = s1Imm[4:0];
            if (!rngIS) encErr = ERR_RANGE;
         end
         3'b010: begin
            encInstr[24:5] = s1Imm[31:12];
            if (|s1Imm[11:0]) encErr = ERR_ALIGN;
         end
         3'b101: begin
            encInstr[24]    = s1Imm[12];
            encInstr[23:18] = s1Imm[10:5];
            encInstr[4:1]   = s1Imm[4:1];
            encInstr[0]     = s1Imm[11];
            if (s1Imm[0])   encErr = ERR_ALIGN;
            else if (!rngB) encErr = ERR_RANGE;
         end
         3'b110: begin
            encInstr[24]    = s1Imm[20];
            encInstr[23:14] = s1Imm[10:1];
            encInstr[13]    = s1Imm[11];
            encInstr[12:5]  = s1Imm[19:12];
            if (s1Imm[0])   encErr = ERR_ALIGN;
            else if (!rngJ) encErr = ERR_RANGE;
         end
         default: begin
            encInstr = '0;
            encErr   = ERR_FMT;
         end
      endcase
   end

   // Two-stage pipeline; S2 holds its contents while stalled by out_ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid <= 1'b0;
         s1Src   <= '0;
         s1Imm   <= '0;
         s2Valid <= 1'b0;
         s2Instr <= '0;
         s2Err   <= ERR_OK;
      end else begin
         if (s2Adv) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
               s2Instr <= encInstr;
               s2Err   <= encErr;
            end
         end
         if (s1Adv) begin
            s1Valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1Src <= bus.ImmSrc;
               s1Imm <= bus.ImmIn;
            end
         end
      end
   end

   // Saturating count of delivered results that carry an error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         errCnt <= '0;
      end else if (s2Valid && bus.out_ready && (s2Err != ERR_OK) && (errCnt != 8'hFF)) begin
         errCnt <= errCnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_imm_enc.sv
// tb/tb_imm_enc.sv - directed and round-trip bench for imm_enc
module tb_imm_enc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   imm_enc_if bus ();
   imm_enc dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [24:0] instr;
      logic [1:0]  err;
   } outRec_t;

   typedef struct {
      logic [2:0]  src;
      logic [31:0] imm;
      logic [24:0] expInstr;
      logic [1:0]  expErr;
   } vec_t;

   outRec_t outQ[$];
   int      accQ[$];

   // Record transfers mid-cycle, after inputs and in_ready have settled
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) outQ.push_back('{cyc, bus.Instr, bus.ErrCode});
         if (bus.in_valid && bus.in_ready) accQ.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic send(input logic [2:0] src, input logic [31:0] imm);
      bit ok = 0;
      bus.in_valid = 1'b1;
      bus.ImmSrc   = src;
      bus.ImmIn    = imm;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input int n);
      for (int t = 0; t < 1000 && outQ.size() < n; t++) @(posedge clk);
      if (outQ.size() < n) chk("drain_count", outQ.size(), n);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] immGen(input logic [2:0] src, input logic [24:0] ins);
      logic [31:0] i;
      i = {ins, 7'b0};
      case (src)
         3'b000:  return {{20{i[31]}}, i[31:20]};
         3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
         3'b010:  return {i[31:12], 12'b0};
         3'b101:  return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
         3'b110:  return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
         default: return 32'd0;
      endcase
   endfunction

   initial begin
      vec_t        tbl[9];
      vec_t        bp[4];
      vec_t        rtQ[$];
      logic [2:0]  fmts[5];
      logic [24:0] snap;
      logic [31:0] r;
      logic [31:0] imm;
      bit          bpDone;
      int          n;

      tbl[0] = '{3'b000, 32'hFFFFF800, 25'h1000000, 2'b00};
      tbl[1] = '{3'b001, 32'h000002B5, 25'h0540015, 2'b00};
      tbl[2] = '{3'b101, 32'hFFFFFFF6, 25'h1FC0017, 2'b00};
      tbl[3] = '{3'b010, 32'h33333000, 25'h0666660, 2'b00};
      tbl[4] = '{3'b110, 32'hFFFFFF32, 25'h1E67FE0, 2'b00};
      tbl[5] = '{3'b000, 32'h00000800, 25'h1000000, 2'b01};
      tbl[6] = '{3'b101, 32'h00000005, 25'h0000004, 2'b10};
      tbl[7] = '{3'b010, 32'h00001001, 25'h0000020, 2'b10};
      tbl[8] = '{3'b011, 32'h00000000, 25'h0000000, 2'b11};

      bp[0] = '{3'b000, 32'h00000123, 25'h0246000, 2'b00};
      bp[1] = '{3'b001, 32'hFFFFFFFF, 25'h1FC001F, 2'b00};
      bp[2] = '{3'b010, 32'hABCDE000, 25'h1579BC0, 2'b00};
      bp[3] = '{3'b110, 32'h00000002, 25'h0004000, 2'b00};

      fmts = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};

      bus.in_valid  = 1'b0;
      bus.ImmSrc    = '0;
      bus.ImmIn     = '0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_instr", bus.Instr, 0);
      chk("rst_errcode", bus.ErrCode, 0);
      chk("rst_errcount", bus.ErrCount, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);

      // Table: legal and error encodes back-to-back
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      foreach (tbl[k]) send(tbl[k].src, tbl[k].imm);
      drain(9);
      for (int k = 0; k < 9 && k < outQ.size() && k < accQ.size(); k++) begin
         chk($sformatf("tbl%0d_instr", k), outQ[k].instr, tbl[k].expInstr);
         chk($sformatf("tbl%0d_err", k), outQ[k].err, tbl[k].expErr);
         chk($sformatf("tbl%0d_latency", k), outQ[k].cyc - accQ[k], 2);
      end
      chk("tbl_errcount", bus.ErrCount, 4);

      // Backpressure: out_ready low for 5 cycles with requests pending
      outQ.delete();
      accQ.delete();
      bus.out_ready = 1'b0;
      bpDone = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(bp[i].src, bp[i].imm);
            bpDone = 1;
         end
      join_none
      repeat (2) @(posedge clk);
      @(negedge clk);
      snap = bus.Instr;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("bp_accepts", accQ.size(), 2);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_stable", bus.Instr, snap);
      chk("bp_head", bus.Instr, bp[0].expInstr);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 200 && !bpDone; t++) @(posedge clk);
      chk("bp_done", bpDone, 1);
      drain(4);
      chk("bp_count", outQ.size(), 4);
      for (int k = 0; k < 4 && k < outQ.size(); k++) begin
         chk($sformatf("bp%0d_instr", k), outQ[k].instr, bp[k].expInstr);
         chk($sformatf("bp%0d_err", k), outQ[k].err, 2'b00);
      end

      // Round trip through a reference immediate generator
      foreach (fmts[f]) begin
         outQ.delete();
         rtQ.delete();
         for (int i = 0; i < 1000; i++) begin
            r = $urandom;
            case (fmts[f])
               3'b000, 3'b001: imm = {{20{r[11]}}, r[11:0]};
               3'b010:         imm = {r[31:12], 12'b0};
               3'b101:         imm = {{19{r[12]}}, r[12:1], 1'b0};
               default:        imm = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            rtQ.push_back('{fmts[f], imm, 25'd0, 2'b00});
            send(fmts[f], imm);
         end
         drain(1000);
         n = 0;
         for (int k = 0; k < outQ.size() && k < rtQ.size(); k++) begin
            if (immGen(rtQ[k].src, outQ[k].instr) !== rtQ[k].imm || outQ[k].err !== 2'b00) begin
               if (n < 5) chk($sformatf("rt_f%0d_%0d", fmts[f], k),
                              immGen(rtQ[k].src, outQ[k].instr), rtQ[k].imm);
               n++;
            end
         end
         chk($sformatf("rt_f%0d_bad", fmts[f]), n, 0);
      end

      // Saturation of the error counter
      outQ.delete();
      for (int i = 0; i < 300; i++) send(3'b111, 32'h0);
      drain(300);
      chk("sat_count", outQ.size(), 300);
      chk("sat_errcount", bus.ErrCount, 255);

      // Reset with both stages full
      outQ.delete();
      accQ.delete();
      bus.out_ready = 1'b0;
      send(3'b000, 32'h00000001);
      send(3'b000, 32'h00000002);
      @(negedge clk);
      chk("mid_full_out_valid", bus.out_valid, 1);
      chk("mid_full_in_ready", bus.in_ready, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_out_valid", bus.out_valid, 0);
      chk("mid_errcount", bus.ErrCount, 0);
      chk("mid_instr", bus.Instr, 0);
      chk("mid_in_ready", bus.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      outQ.delete();
      accQ.delete();
      bus.out_ready = 1'b1;
      send(3'b110, 32'hFFFFFF32);
      drain(1);
      chk("post_count", outQ.size(), 1);
      if (outQ.size() > 0 && accQ.size() > 0) begin
         chk("post_instr", outQ[0].instr, 25'h1E67FE0);
         chk("post_err", outQ[0].err, 2'b00);
         chk("post_latency", outQ[0].cyc - accQ[0], 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/imm_enc.md
# imm_enc

Pipelined immediate encoder: the inverse of the core's immediate generator. It takes a 32-bit immediate value and an immediate format code, and produces the instruction bits [31:7] that carry that immediate. All non-immediate bit positions (rd, rs1, rs2, funct3) are zero. It also flags immediates that cannot be encoded. It sits in the assembler/self-test path, feeding generated instructions to instruction memory, and is used for round-trip checks against the immediate generator.

## Interface
- No parameters. All widths are fixed by the RV32I encoding.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at a rising edge.
- ImmSrc  in  3  format code: 000 I, 001 S, 010 U, 101 B, 110 J; all other codes are illegal.
- ImmIn  in  32  immediate value. Signed for I/S/B/J. For U it is the full value, with bits [11:0] expected to be zero.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready at a rising edge.
- Instr  out  25  encoded instruction[31:7].
- ErrCode  out  2  error code: 00 ok, 01 out of range, 10 misaligned, 11 illegal format.
- ErrCount  out  8  saturating count of delivered results with ErrCode != 00.

## Operation
- Bit mapping, where Instr[i] is instruction bit i+7. Unlisted Instr bits are 0.
  - I: Instr[24:13]=ImmIn[11:0].
  - S: Instr[24:18]=ImmIn[11:5], Instr[4:0]=ImmIn[4:0].
  - U: Instr[24:5]=ImmIn[31:12].
  - B: Instr[24]=ImmIn[12], Instr[23:18]=ImmIn[10:5], Instr[4:1]=ImmIn[4:1], Instr[0]=ImmIn[11].
  - J: Instr[24]=ImmIn[20], Instr[23:14]=ImmIn[10:1], Instr[13]=ImmIn[11], Instr[12:5]=ImmIn[19:12].
- Range rules (the listed bits must all be equal to each other):
  - I/S: ImmIn[31:11].
  - B: ImmIn[31:12].
  - J: ImmIn[31:20].
- Alignment rules:
  - U: ImmIn[11:0] must be 0; a violation is reported as misaligned.
  - B/J: ImmIn[0] must be 0.
- Error priority: illegal format > misaligned > out of range.
  - On illegal format, Instr = 0.
  - On other errors, Instr still carries the truncated mapping shown above. This output is deterministic and checked by the bench.
- Pipeline: two stages with a valid bit each.
  - S1 registers ImmSrc/ImmIn.
  - S2 registers Instr/ErrCode, computed combinationally from S1.
- ErrCount increments by 1 on each output transfer with ErrCode != 00. It saturates at 255 and does not wrap.

## Timing
- Reset (async assert, released synchronously by clk):
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - Instr = 0, ErrCode = 00, ErrCount = 0.
  - in_ready = 1 once rst is low.
- Stall logic:
  - s2_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_adv. This is a combinational path from out_ready and is permitted.
- Latency: a request accepted at edge k appears with out_valid = 1 after edge k+1. Throughput is 1 result per cycle while out_ready = 1.
- Backpressure:
  - While out_valid && !out_ready, the S2 contents are held stable.
  - S1 fills, then in_ready drops.
  - No request may be lost or duplicated.
- Simultaneous in/out transfer in the same cycle with both stages full: S2 takes S1, S1 takes the new request, and all stages stay full.
- ErrCount updates on the same edge as the output transfer.
- Reset mid-operation: in-flight requests are discarded, and all outputs return to reset values immediately on rst assertion.

## Test plan
- Legal encodes, one per cycle, out_ready = 1. Every result has ErrCode = 00.
  - I, ImmIn = 0xFFFFF800 -> Instr = 0x1000000.
  - S, 0x000002B5 -> 0x0540015.
  - B, 0xFFFFFFF6 -> 0x1FC0017.
  - U, 0x33333000 -> 0x0666660.
  - J, 0xFFFFFF32 -> 0x1E67FE0.
  - Each result appears 2 edges after acceptance, back-to-back.
- Error cases:
  - I 0x00000800 -> ErrCode = 01, Instr = 0x1000000.
  - B 0x00000005 -> ErrCode = 10.
  - U 0x00001001 -> ErrCode = 10.
  - ImmSrc = 011 -> ErrCode = 11, Instr = 0.
  - After all four, ErrCount = 4.
- Backpressure: hold out_ready = 0 for 5 cycles while in_valid = 1.
  - in_ready drops after 2 accepts.
  - Instr/ErrCode stay stable.
  - On release, all requests emerge in order with no loss or duplication.
- Round trip: feed 1000 random legal immediates per format through imm_enc, then the immediate generator. ImmExt must equal ImmIn for every result.
- Saturation: 300 illegal-format requests -> ErrCount stops at 255.
- Reset mid-stream: assert rst with both stages full.
  - out_valid = 0 and ErrCount = 0 immediately.
  - The first request after release emerges correctly with 2-edge latency.
